adder_multicycle_chunked: RTL and testbench

ADDER_MULTICYCLE_CHUNKED -- requirements
Module: adder_multicycle_chunked

---
 rtl/adder_pkg.sv | 13 +
 rtl/full_adder_chunk.sv | 13 +
 rtl/adder_multicycle_chunked.sv | 124 ++++++++++++
 tb/tb_adder_multicycle_chunked.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder: FSM encoding and default sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/full_adder_chunk.sv
// Purely combinational CHUNK-bit adder with carry-in; F_o = {carry_out, sum}.
module full_adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] A_i,
    input  logic [CHUNK-1:0] B_i,
    input  logic             C_i,
    output logic [CHUNK:0]   F_o
);

    assign F_o = {1'b0, A_i} + {1'b0, B_i} + {{CHUNK{1'b0}}, C_i};

endmodule

// File: rtl/adder_multicycle_chunked.sv
// Multi-cycle adder: F_o = A_i + B_i + C_i computed CHUNK bits per cycle, low chunk first,
// with a valid/ready handshake on both operand and result sides.
module adder_multicycle_chunked
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   F_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $fatal(1, "adder_multicycle_chunked: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     f_q, f_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     fa_f;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    full_adder_chunk #(
        .CHUNK (CHUNK)
    ) u_fa (
        .A_i (a_chunk),
        .B_i (b_chunk),
        .C_i (carry_q),
        .F_o (fa_f)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    carry_d = C_i;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[idx_q*CHUNK +: CHUNK] = fa_f[CHUNK-1:0];
                carry_d = fa_f[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                // Result register is loaded only here, so F_o holds across DONE and IDLE.
                if (idx_q == LAST_IDX) begin
                    f_d     = {fa_f[CHUNK], sum_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign F_o         = f_q;

endmodule

// File: tb/tb_adder_multicycle_chunked.sv
// Directed bench for the chunked adder: a 32/8 instance and an 8/8 instance sharing clock and reset.
module tb_adder_multicycle_chunked;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32, c_32;
    logic [31:0] a_32, b_32;
    logic [32:0] f_32;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, c_8;
    logic [7:0]  a_8, b_8;
    logic [8:0]  f_8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    adder_multicycle_chunked #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_32),
        .in_ready_o  (in_ready_32),
        .A_i         (a_32),
        .B_i         (b_32),
        .C_i         (c_32),
        .out_valid_o (out_valid_32),
        .out_ready_i (out_ready_32),
        .F_o         (f_32)
    );

    adder_multicycle_chunked #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_8),
        .in_ready_o  (in_ready_8),
        .A_i         (a_8),
        .B_i         (b_8),
        .C_i         (c_8),
        .out_valid_o (out_valid_8),
        .out_ready_i (out_ready_8),
        .F_o         (f_8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation, scramble the operand inputs, then time and check the result.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [32:0] exp);
        int cyc;
        chk({tag, "_ready"}, 64'(in_ready_32), 64'd1);
        in_valid_32 = 1'b1; a_32 = a; b_32 = b; c_32 = c; out_ready_32 = 1'b0;
        @(negedge clk_i);
        in_valid_32 = 1'b0; a_32 = ~a; b_32 = ~b; c_32 = ~c;
        chk({tag, "_busy"}, 64'(in_ready_32), 64'd0);
        cyc = 0;
        while (!out_valid_32 && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd4);
        chk({tag, "_F"}, 64'(f_32), 64'(exp));
        out_ready_32 = 1'b1;
        @(negedge clk_i);
        out_ready_32 = 1'b0;
        chk({tag, "_idle"}, {62'd0, in_ready_32, out_valid_32}, 64'd2);
        chk({tag, "_hold"}, 64'(f_32), 64'(exp));
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [8:0] exp);
        int cyc;
        in_valid_8 = 1'b1; a_8 = a; b_8 = b; c_8 = c; out_ready_8 = 1'b0;
        @(negedge clk_i);
        in_valid_8 = 1'b0; a_8 = ~a; b_8 = ~b; c_8 = ~c;
        cyc = 0;
        while (!out_valid_8 && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd1);
        chk({tag, "_F"}, 64'(f_8), 64'(exp));
        out_ready_8 = 1'b1;
        @(negedge clk_i);
        out_ready_8 = 1'b0;
        chk({tag, "_idle"}, {62'd0, in_ready_8, out_valid_8}, 64'd2);
    endtask

    initial begin
        int seen;
        rst_i = 1'b1;
        in_valid_32 = 1'b0; out_ready_32 = 1'b0; a_32 = '0; b_32 = '0; c_32 = 1'b0;
        in_valid_8  = 1'b0; out_ready_8  = 1'b0; a_8  = '0; b_8  = '0; c_8  = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_init", {f_32, 29'd0, in_ready_32, out_valid_32}, 64'd2);
        rst_i = 1'b0;
        @(negedge clk_i);

        op32("ovf",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        op32("cin",   32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001);
        op32("mix",   32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);
        op32("ripl",  32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100);
        op32("max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);

        // Backpressure: result must hold and new operands must be refused.
        in_valid_32 = 1'b1; a_32 = 32'h0000_0003; b_32 = 32'h0000_0004; c_32 = 1'b0;
        @(negedge clk_i);
        in_valid_32 = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            in_valid_32 = (i != 1); a_32 = 32'hDEAD_0000; b_32 = 32'h0000_BEEF;
            chk("bp_F", 64'(f_32), 64'h7);
            chk("bp_flags", {62'd0, in_ready_32, out_valid_32}, 64'd1);
            @(negedge clk_i);
        end
        in_valid_32 = 1'b0;
        chk("bp_F_end", 64'(f_32), 64'h7);
        out_ready_32 = 1'b1;
        @(negedge clk_i);
        out_ready_32 = 1'b0;
        @(negedge clk_i);
        chk("bp_no_accept", {62'd0, in_ready_32, out_valid_32}, 64'd2);

        // Asynchronous reset while a result is pending in DONE.
        in_valid_32 = 1'b1; a_32 = 32'h0000_0010; b_32 = 32'h0000_0020; c_32 = 1'b0;
        @(negedge clk_i);
        in_valid_32 = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("pre_rst_F", 64'(f_32), 64'h30);
        #2 rst_i = 1'b1;
        #1 chk("rst_async", {f_32, 29'd0, in_ready_32, out_valid_32}, 64'd2);
        in_valid_32 = 1'b1; a_32 = 32'h0000_0001; b_32 = 32'h0000_0001;
        @(negedge clk_i);
        @(negedge clk_i);
        in_valid_32 = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ignore_valid", {f_32, 29'd0, in_ready_32, out_valid_32}, 64'd2);

        // Abort in CALC at idx==2; no result may appear afterwards.
        in_valid_32 = 1'b1; a_32 = 32'hFFFF_FFFF; b_32 = 32'h0000_0001; c_32 = 1'b0;
        @(negedge clk_i);
        in_valid_32 = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (out_valid_32) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        op32("after_abort", 32'h0000_0005, 32'h0000_0007, 1'b0, 33'h0_0000_000C);

        op8("w8_a", 8'h80, 8'h80, 1'b1, 9'h101);
        op8("w8_b", 8'hFF, 8'h00, 1'b1, 9'h100);
        op8("w8_c", 8'h0F, 8'h01, 1'b0, 9'h010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
